// File: rtl/usadd_pkg.sv
// Shared types and width helpers for the stochastic-adder scheduler.
package usadd_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  function automatic int result_width(input int bitwidth, input int binput);
    return bitwidth + binput + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/usadd_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module usadd_rr_arb
  import usadd_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]            req_i,
  input  logic [idx_width(NREQ)-1:0] ptr_i,
  output logic [idx_width(NREQ)-1:0] win_o,
  output logic                       any_o
);

  localparam int IW = idx_width(NREQ);

  // Scan from the farthest offset down so the closest requester to ptr wins last.
  always_comb begin
    int idx;
    idx   = 0;
    win_o = ptr_i;
    any_o = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % NREQ;
      if (req_i[idx]) begin
        win_o = IW'(idx);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/usadd_sched.sv
// Round-robin scheduler sharing one unipolar stochastic adder datapath among NREQ requesters.
//
// state | meaning
// IDLE  | waiting for any request; arbiter picks winner into oId
// LOAD  | one cycle: load B operand, clear RNG, window counter and accumulator
// RUN   | 2^BITWIDTH cycles streaming granted iA into the datapath
// DRAIN | PIPE cycles flushing the datapath pipeline into the accumulator
// DONE  | result valid, held until iAck
module usadd_sched
  import usadd_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int NREQ     = 4,
  parameter int BINPUT   = 2,
  parameter int PIPE     = 3
) (
  input  logic                                        iClk,
  input  logic                                        iRst,
  input  logic [NREQ-1:0]                             iReq,
  input  logic [NREQ*BITWIDTH-1:0]                    iB,
  input  logic [NREQ-1:0]                             iA,
  output logic [NREQ-1:0]                             oGnt,
  output logic                                        oRun,
  output logic                                        dpA,
  output logic [BITWIDTH-1:0]                         dpB,
  output logic                                        dpLoadB,
  output logic                                        dpClr,
  input  logic [BINPUT-1:0]                           dpOut,
  output logic                                        oValid,
  output logic [result_width(BITWIDTH, BINPUT)-1:0]   oResult,
  output logic [idx_width(NREQ)-1:0]                  oId,
  input  logic                                        iAck
);

  localparam int IW = idx_width(NREQ);
  localparam int RW = result_width(BITWIDTH, BINPUT);
  localparam int DW = (PIPE > 1) ? $clog2(PIPE) : 1;

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        id_q, id_d;
  logic [BITWIDTH-1:0]  dpb_q, dpb_d;
  logic [BITWIDTH-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]        drain_q, drain_d;
  logic [RW-1:0]        acc_q, acc_d;

  logic [IW-1:0]        arb_win;
  logic                 arb_any;
  logic [RW-1:0]        dp_ext;

  usadd_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i (iReq),
    .ptr_i (ptr_q),
    .win_o (arb_win),
    .any_o (arb_any)
  );

  assign dp_ext = {{(RW-BINPUT){1'b0}}, dpOut};

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      dpb_q   <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      dpb_q   <= dpb_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    dpb_d   = dpb_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    acc_d   = acc_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          id_d    = arb_win;
          // Captured at the grant edge so dpB is registered while LOAD presents it.
          dpb_d   = iB[arb_win*BITWIDTH +: BITWIDTH];
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        acc_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = acc_q + dp_ext;
        if (&cnt_q) begin
          drain_d = DW'(PIPE > 0 ? PIPE - 1 : 0);
          state_d = (PIPE == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        acc_d = acc_q + dp_ext;
        if (drain_q == '0) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      DONE: begin
        if (iAck) begin
          ptr_d   = (id_q == IW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign oGnt    = (state_q == IDLE) ? '0 : (NREQ'(1) << id_q);
  assign oRun    = (state_q == RUN);
  assign dpA     = (state_q == RUN) ? iA[id_q] : 1'b0;
  assign dpB     = dpb_q;
  assign dpLoadB = (state_q == LOAD);
  assign dpClr   = (state_q == LOAD);
  assign oValid  = (state_q == DONE);
  assign oResult = acc_q;
  assign oId     = id_q;

endmodule

// File: tb/tb_usadd_sched.sv
// Directed, table-driven bench for usadd_sched with a constant-output datapath stub.
module tb_usadd_sched;

  localparam int BITWIDTH = 8;
  localparam int NREQ     = 4;
  localparam int BINPUT   = 2;
  localparam int PIPE     = 3;
  localparam int RW       = BITWIDTH + BINPUT + 1;
  localparam int LAT      = 261;

  logic                     iClk = 1'b0;
  logic                     iRst;
  logic [NREQ-1:0]          iReq;
  logic [NREQ*BITWIDTH-1:0] iB;
  logic [NREQ-1:0]          iA;
  logic [NREQ-1:0]          oGnt;
  logic                     oRun;
  logic                     dpA;
  logic [BITWIDTH-1:0]      dpB;
  logic                     dpLoadB;
  logic                     dpClr;
  logic [BINPUT-1:0]        dpOut;
  logic                     oValid;
  logic [RW-1:0]            oResult;
  logic [1:0]               oId;
  logic                     iAck;

  int tests = 0;
  int fails = 0;

  logic [7:0] bval [4];

  typedef struct {
    logic [3:0]  req;
    logic [1:0]  dpo;
    int          ackwait;
    logic [1:0]  id;
    logic [10:0] res;
  } vec_t;

  vec_t vecs [11];

  usadd_sched #(
    .BITWIDTH (BITWIDTH),
    .NREQ     (NREQ),
    .BINPUT   (BINPUT),
    .PIPE     (PIPE)
  ) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iReq    (iReq),
    .iB      (iB),
    .iA      (iA),
    .oGnt    (oGnt),
    .oRun    (oRun),
    .dpA     (dpA),
    .dpB     (dpB),
    .dpLoadB (dpLoadB),
    .dpClr   (dpClr),
    .dpOut   (dpOut),
    .oValid  (oValid),
    .oResult (oResult),
    .oId     (oId),
    .iAck    (iAck)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Entered at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_job(input int tag, input logic [3:0] req, input logic [1:0] dpo,
                         input int ackwait, input int drop_at,
                         input logic [1:0] exp_id, input logic [10:0] exp_res);
    int cyc, runs, gerr, aerr, serr, lerr, lat;
    logic seen, exp_a;
    logic [3:0] oh;
    logic [10:0] res0;
    oh = 4'b0001 << exp_id;
    iReq = req;
    dpOut = dpo;
    cyc = 0; runs = 0; gerr = 0; aerr = 0; serr = 0; lerr = 0; lat = 0;
    seen = 1'b0;
    @(posedge iClk);
    while (!seen && cyc < 400) begin
      #1;
      iA = 4'($urandom);
      cyc++;
      if (cyc == drop_at) iReq = '0;
      @(negedge iClk);
      if (cyc == 1) chk($sformatf("job%0d_dpB", tag), dpB, bval[exp_id]);
      if ((dpLoadB !== (cyc == 1)) || (dpClr !== (cyc == 1))) lerr++;
      if (oRun) runs++;
      exp_a = (cyc >= 2 && cyc <= 257) ? iA[exp_id] : 1'b0;
      if (dpA !== exp_a) aerr++;
      if (oGnt !== oh) gerr++;
      if (oValid) begin
        seen = 1'b1;
        lat = cyc;
      end else begin
        @(posedge iClk);
      end
    end
    chk($sformatf("job%0d_latency", tag), lat, LAT);
    chk($sformatf("job%0d_id", tag), oId, exp_id);
    chk($sformatf("job%0d_result", tag), oResult, exp_res);
    chk($sformatf("job%0d_run_cycles", tag), runs, 256);
    chk($sformatf("job%0d_grant_errs", tag), gerr, 0);
    chk($sformatf("job%0d_dpA_errs", tag), aerr, 0);
    chk($sformatf("job%0d_strobe_errs", tag), lerr, 0);
    res0 = oResult;
    for (int w = 0; w < ackwait; w++) begin
      @(posedge iClk);
      #1 iA = 4'($urandom);
      @(negedge iClk);
      if (!oValid || oResult !== res0 || oId !== exp_id || oGnt !== oh || dpLoadB || oRun) serr++;
    end
    if (ackwait > 0) chk($sformatf("job%0d_hold_errs", tag), serr, 0);
    iAck = 1'b1;
    @(posedge iClk);
    #1 iAck = 1'b0;
    @(negedge iClk);
    chk($sformatf("job%0d_after_ack", tag), {oValid, oGnt}, 5'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int verr;
    bval[0] = 8'd128; bval[1] = 8'h11; bval[2] = 8'h22; bval[3] = 8'h33;
    vecs[0]  = '{4'b0001, 2'd1, 0,  2'd0, 11'd259};
    vecs[1]  = '{4'b0001, 2'd3, 0,  2'd0, 11'd777};
    vecs[2]  = '{4'b1111, 2'd2, 0,  2'd1, 11'd518};
    vecs[3]  = '{4'b1111, 2'd0, 0,  2'd2, 11'd0};
    vecs[4]  = '{4'b1111, 2'd1, 0,  2'd3, 11'd259};
    vecs[5]  = '{4'b1111, 2'd3, 0,  2'd0, 11'd777};
    vecs[6]  = '{4'b1010, 2'd1, 0,  2'd1, 11'd259};
    vecs[7]  = '{4'b1010, 2'd2, 0,  2'd3, 11'd518};
    vecs[8]  = '{4'b1010, 2'd3, 0,  2'd1, 11'd777};
    vecs[9]  = '{4'b1111, 2'd1, 50, 2'd2, 11'd259};
    vecs[10] = '{4'b1111, 2'd2, 0,  2'd3, 11'd518};

    iRst = 1'b1;
    iReq = '0;
    iA = '0;
    iAck = 1'b0;
    dpOut = '0;
    iB = {bval[3], bval[2], bval[1], bval[0]};
    repeat (2) @(negedge iClk);
    chk("reset_outputs", {oGnt, oRun, dpA, dpB, dpLoadB, dpClr, oValid, oResult, oId}, 32'd0);
    iRst = 1'b0;
    @(negedge iClk);

    for (int i = 0; i < 11; i++)
      run_job(i, vecs[i].req, vecs[i].dpo, vecs[i].ackwait, 0, vecs[i].id, vecs[i].res);

    // Requester 2 drops its request mid-RUN; the job must still complete.
    run_job(11, 4'b0100, 2'd3, 0, 100, 2'd2, 11'd777);

    // Reset in RUN cycle 100 aborts the job; the next grant restarts from ptr 0.
    iReq = 4'b1111;
    dpOut = 2'd1;
    @(posedge iClk);
    for (int c = 1; c <= 100; c++) begin
      #1 iA = 4'($urandom);
      @(negedge iClk);
      if (c < 100) @(posedge iClk);
    end
    chk("pre_reset_running", {oRun, oId}, {1'b1, 2'd3});
    iRst = 1'b1;
    #1;
    chk("async_reset_outputs", {oGnt, oRun, dpA, dpB, dpLoadB, dpClr, oValid, oResult, oId}, 32'd0);
    verr = 0;
    repeat (3) begin
      @(negedge iClk);
      if (oValid || oGnt != 4'd0) verr++;
    end
    chk("reset_hold_quiet", verr, 0);
    iRst = 1'b0;
    run_job(12, 4'b1111, 2'd1, 0, 0, 2'd0, 11'd259);
    iReq = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/usadd_sched.md
# usadd_sched

Round-robin scheduler that shares one unipolar stochastic adder datapath (Sobol B-stream generator plus parallel counter and accumulator) among NREQ requesters. It grants one requester at a time and loads that requester's binary B operand into the datapath. It clears the RNG, streams the requester's unary A bits for a full 2^BITWIDTH-cycle window, drains the datapath pipeline, and returns the accumulated output count through a valid/ack handshake. It sits between the requester array and a single adder instance.

## Interface
- BITWIDTH, 8, operand width; stream window = 2^BITWIDTH cycles
- NREQ, 4, number of requesters (≥2)
- BINPUT, 2, width of the datapath output word
- PIPE, 3, datapath latency in cycles; drain length after the stream ends
- iClk  in  1  clock, rising edge
- iRst  in  1  reset, asynchronous, active-high
- iReq  in  NREQ  per-requester job request, level
- iB  in  NREQ*BITWIDTH  per-requester B operand; slice k = [k*BITWIDTH +: BITWIDTH]
- iA  in  NREQ  per-requester unary A stream bit
- oGnt  out  NREQ  one-hot grant; held from LOAD through DONE
- oRun  out  1  high in RUN cycles; the granted requester's iA is consumed in those cycles
- dpA  out  1  A bit to datapath
- dpB  out  BITWIDTH  B operand to datapath
- dpLoadB  out  1  B load strobe to datapath
- dpClr  out  1  RNG clear to datapath
- dpOut  in  BINPUT  datapath output word
- oValid  out  1  result valid
- oResult  out  BITWIDTH+BINPUT+1  accumulated sum of dpOut over RUN+DRAIN
- oId  out  $clog2(NREQ)  index of the requester that owns oResult
- iAck  in  1  result accepted

## Operation
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: if iReq is nonzero, the round-robin arbiter picks the first requesting index at or after pointer ptr, wrapping. The winner is latched into oId and the next state is LOAD. If iReq is zero, stay in IDLE.
- LOAD (1 cycle): oGnt=onehot(oId), dpLoadB=1, dpB=iB[oId], dpClr=1; clear the window counter and the accumulator.
- RUN (2^BITWIDTH cycles): dpA=iA[oId], oRun=1, window counter increments, accumulator += dpOut. Leave after counter reaches 2^BITWIDTH−1.
- DRAIN (PIPE cycles): dpA=0, accumulator += dpOut. If PIPE=0, skip straight to DONE.
- DONE: oValid=1 and oResult/oId are held stable. On iAck=1, go to IDLE and set ptr=(oId+1) mod NREQ.
- Outside LOAD, dpB holds its last value and dpLoadB=dpClr=0. dpA=0 outside RUN. oGnt=0 in IDLE.
- A job is committed once granted. Dropping iReq mid-job does not abort it. iA/iB of non-granted requesters are ignored.
- Accumulator width BITWIDTH+BINPUT+1; the maximum (2^BITWIDTH+PIPE)·(2^BINPUT−1) never overflows for PIPE ≤ 2^BITWIDTH.
- iAck outside DONE is ignored.

## Timing
- Reset (async assert): state=IDLE, ptr=0, oGnt=0, oRun=0, dpA=0, dpB=0, dpLoadB=0, dpClr=0, oValid=0, oResult=0, oId=0. Any in-flight job is discarded. The first job after release starts from ptr=0.
- All outputs are registered or decoded from registered state only; there are no combinational paths from iReq/iAck to outputs. dpA is the one exception: it is a registered-state-gated mux of iA.
- Request sampled at edge 0 → LOAD in cycle 1 → RUN in cycles 2..2^BITWIDTH+1 → DRAIN for PIPE cycles → oValid rises in cycle 2^BITWIDTH+PIPE+2. With defaults, that is cycle 261.
- iAck sampled high while oValid=1 → oValid=0 next cycle and the state returns to IDLE. There is at least one IDLE cycle between jobs, so back-to-back job spacing is 2^BITWIDTH+PIPE+3 cycles minimum.
- iAck held high continuously: each result is valid for exactly one cycle.

## Structure
- Shared package usadd_pkg: state enum (IDLE, LOAD, RUN, DRAIN, DONE), a result-width function (BITWIDTH+BINPUT+1), and an index-width helper.
- One sub-module: usadd_rr_arb, a combinational NREQ-way round-robin picker. Inputs are req and ptr; outputs are winner index and any. The FSM, counters and accumulator stay in usadd_sched.

## Test plan
- Single requester 0, iB=128, datapath stub drives dpOut=1 every cycle → oGnt=0001 at cycle 1, dpLoadB/dpClr pulse at cycle 1, 256 oRun cycles, oValid at cycle 261, oResult=259, oId=0.
- Stub dpOut=3 every cycle → oResult=777, with no overflow.
- All four requesters hold iReq with immediate iAck → oId sequence 0,1,2,3,0 and grants always one-hot. Requests only on 1 and 3 → sequence 1,3,1.
- iAck held low for 50 cycles in DONE → oValid/oResult/oId stable and no new grant despite pending requests. After iAck, the next grant goes to the next RR index.
- Requester 2 drops iReq in the middle of RUN → job still completes with oId=2. dpA tracks iA[2] only; toggling iA[0] has no effect.
- iRst pulsed during RUN cycle 100 → all outputs zero immediately, with no oValid for the aborted job. The next job is granted from ptr=0 with full 261-cycle latency.
